// File: rtl/regbank_mp.sv
// regbank_mp: multi-port register file (GP + stack registers) with
// same-cycle write bypass and a per-register busy scoreboard.
module regbank_mp #(
    parameter int XLEN = 64,
    parameter int NGP = 16,
    parameter int NSTK = 2,
    parameter int NRD = 3,
    parameter logic [XLEN-1:0] GP_RESET_VALUE = {XLEN{1'b1}},
    parameter logic [XLEN-1:0] STACK_RESET_VALUE = '0,
    localparam int NREG = NGP + NSTK,
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_idx,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_idx,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_idx,
    output logic                busy_any
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wr0_hit;
    logic [NREG-1:0] wr1_hit;
    logic [NREG-1:0] iss_hit;

    // One-hot decode; indices >= NREG match no register and are dropped.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr0_hit[r] = wr0_en && (wr0_idx == AW'(r));
            wr1_hit[r] = wr1_en && (wr1_idx == AW'(r));
            iss_hit[r] = iss_en && (iss_idx == AW'(r));
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        localparam logic [XLEN-1:0] RST =
            (g < NGP) ? GP_RESET_VALUE : STACK_RESET_VALUE;

        always_ff @(posedge clk) begin
            if (reset) begin
                regs[g] <= RST;
            end else if (wr1_hit[g]) begin
                regs[g] <= wr1_data;
            end else if (wr0_hit[g]) begin
                regs[g] <= wr0_data;
            end
        end

        // A new claim outranks a completing write to the same register.
        always_ff @(posedge clk) begin
            if (reset) begin
                busy[g] <= 1'b0;
            end else if (iss_hit[g]) begin
                busy[g] <= 1'b1;
            end else if (wr0_hit[g] || wr1_hit[g]) begin
                busy[g] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign idx = rd_idx[k*AW +: AW];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            for (int r = 0; r < NREG; r++) begin
                if (idx == AW'(r)) begin
                    data = regs[r];
                    if (wr0_hit[r]) data = wr0_data;
                    if (wr1_hit[r]) data = wr1_data;
                    bsy = busy[r] & ~(wr0_hit[r] | wr1_hit[r]);
                end
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k] = bsy;
    end

    assign busy_any = |busy;

endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: scoreboard bench for regbank_mp, default build
// plus an NGP=8 / NSTK=4 / NRD=4 build sharing clock and reset.
module tb_regbank_mp;

    localparam logic [63:0] ONES = {64{1'b1}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [14:0]  a_rd_idx;
    logic [191:0] a_rd_data;
    logic [2:0]   a_rd_busy;
    logic         a_wr0_en, a_wr1_en, a_iss_en, a_busy_any;
    logic [4:0]   a_wr0_idx, a_wr1_idx, a_iss_idx;
    logic [63:0]  a_wr0_data, a_wr1_data;

    logic [15:0]  b_rd_idx;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wr0_en, b_wr1_en, b_iss_en, b_busy_any;
    logic [3:0]   b_wr0_idx, b_wr1_idx, b_iss_idx;
    logic [63:0]  b_wr0_data, b_wr1_data;

    regbank_mp u_a (
        .clk(clk), .reset(reset),
        .rd_idx(a_rd_idx), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr0_en(a_wr0_en), .wr0_idx(a_wr0_idx), .wr0_data(a_wr0_data),
        .wr1_en(a_wr1_en), .wr1_idx(a_wr1_idx), .wr1_data(a_wr1_data),
        .iss_en(a_iss_en), .iss_idx(a_iss_idx), .busy_any(a_busy_any)
    );

    regbank_mp #(.NGP(8), .NSTK(4), .NRD(4)) u_b (
        .clk(clk), .reset(reset),
        .rd_idx(b_rd_idx), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr0_en(b_wr0_en), .wr0_idx(b_wr0_idx), .wr0_data(b_wr0_data),
        .wr1_en(b_wr1_en), .wr1_idx(b_wr1_idx), .wr1_data(b_wr1_data),
        .iss_en(b_iss_en), .iss_idx(b_iss_idx), .busy_any(b_busy_any)
    );

    // src: 0 a.rd_data 1 a.rd_busy 2 a.busy_any 3 b.rd_data 4 b.rd_busy 5 b.busy_any
    typedef struct {
        string       tag;
        int          src;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int src, input int port);
        case (src)
            0: return a_rd_data[port*64 +: 64];
            1: return 64'(a_rd_busy[port]);
            2: return 64'(a_busy_any);
            3: return b_rd_data[port*64 +: 64];
            4: return 64'(b_rd_busy[port]);
            default: return 64'(b_busy_any);
        endcase
    endfunction

    task automatic push(input string tag, input int src, input int port,
                        input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.port = port;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, observe(e.src, e.port), e.exp);
        end
    endtask

    task automatic a_rd(input int k, input logic [4:0] idx);
        a_rd_idx[k*5 +: 5] = idx;
    endtask

    task automatic b_rd(input int k, input logic [3:0] idx);
        b_rd_idx[k*4 +: 4] = idx;
    endtask

    task automatic idle();
        a_wr0_en = 0; a_wr1_en = 0; a_iss_en = 0;
        b_wr0_en = 0; b_wr1_en = 0; b_iss_en = 0;
    endtask

    initial begin
        idle();
        a_rd_idx = '0; b_rd_idx = '0;
        a_wr0_idx = '0; a_wr1_idx = '0; a_iss_idx = '0;
        a_wr0_data = '0; a_wr1_data = '0;
        b_wr0_idx = '0; b_wr1_idx = '0; b_iss_idx = '0;
        b_wr0_data = '0; b_wr1_data = '0;

        // write and issue while in reset must be ignored
        reset = 1;
        a_wr0_en = 1; a_wr0_idx = 0; a_wr0_data = 64'h5;
        a_iss_en = 1; a_iss_idx = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        idle();
        a_rd(0, 0); a_rd(1, 15); a_rd(2, 16);
        b_rd(0, 0); b_rd(1, 7); b_rd(2, 8); b_rd(3, 11);
        push("rst_a_r0", 0, 0, ONES);
        push("rst_a_r15", 0, 1, ONES);
        push("rst_a_r16", 0, 2, 64'h0);
        push("rst_a_busy0", 1, 0, 0);
        push("rst_a_busy1", 1, 1, 0);
        push("rst_a_busy2", 1, 2, 0);
        push("rst_a_any", 2, 0, 0);
        push("rst_b_r0", 3, 0, ONES);
        push("rst_b_r7", 3, 1, ONES);
        push("rst_b_r8", 3, 2, 64'h0);
        push("rst_b_r11", 3, 3, 64'h0);
        push("rst_b_any", 5, 0, 0);
        drain();
        a_rd(0, 17); a_rd(1, 1);
        push("rst_a_r17", 0, 0, 64'h0);
        push("rst_a_r1", 0, 1, ONES);
        push("rst_a_r1_busy", 1, 1, 0);
        drain();

        // dual write, same index: wr1 wins in bypass and in storage
        @(negedge clk);
        a_wr0_en = 1; a_wr0_idx = 3; a_wr0_data = 64'h1234;
        a_wr1_en = 1; a_wr1_idx = 3; a_wr1_data = 64'hABCD;
        a_rd(0, 3);
        push("byp_wr1", 0, 0, 64'hABCD);
        drain();
        a_wr1_en = 0;
        push("byp_wr0", 0, 0, 64'h1234);
        drain();
        a_wr1_en = 1;
        @(negedge clk);
        idle();
        push("r3_wr1_wins", 0, 0, 64'hABCD);
        drain();

        // issue, then write clears busy with bypass
        @(negedge clk);
        a_iss_en = 1; a_iss_idx = 5; a_rd(0, 5);
        push("iss_same_cyc_busy", 1, 0, 0);
        push("iss_same_cyc_any", 2, 0, 0);
        drain();
        @(negedge clk);
        a_iss_en = 0;
        push("r5_busy", 1, 0, 1);
        push("r5_any", 2, 0, 1);
        drain();
        a_wr0_en = 1; a_wr0_idx = 5; a_wr0_data = 64'h55;
        push("r5_byp_data", 0, 0, 64'h55);
        push("r5_byp_busy", 1, 0, 0);
        push("r5_byp_any", 2, 0, 1);
        drain();
        @(negedge clk);
        idle();
        push("r5_clr_any", 2, 0, 0);
        push("r5_clr_busy", 1, 0, 0);
        push("r5_stored", 0, 0, 64'h55);
        drain();

        // issue and write same reg same cycle: set wins
        @(negedge clk);
        a_iss_en = 1; a_iss_idx = 7;
        a_wr1_en = 1; a_wr1_idx = 7; a_wr1_data = 64'h77;
        a_rd(1, 7);
        push("r7_byp", 0, 1, 64'h77);
        drain();
        @(negedge clk);
        idle();
        push("r7_data", 0, 1, 64'h77);
        push("r7_busy", 1, 1, 1);
        push("r7_any", 2, 0, 1);
        drain();
        a_iss_en = 1; a_iss_idx = 7;
        @(negedge clk);
        a_iss_en = 0;
        push("r7_reissue_busy", 1, 1, 1);
        drain();
        a_wr0_en = 1; a_wr0_idx = 7; a_wr0_data = 64'h78;
        @(negedge clk);
        idle();
        push("r7_clr_busy", 1, 1, 0);
        push("r7_clr_any", 2, 0, 0);
        push("r7_new", 0, 1, 64'h78);
        drain();

        // out-of-range write, issue and read
        a_wr0_en = 1; a_wr0_idx = 20; a_wr0_data = 64'h99;
        a_iss_en = 1; a_iss_idx = 20;
        a_rd(2, 20); a_rd(0, 4);
        push("oor_rd", 0, 2, 64'h0);
        push("oor_busy", 1, 2, 0);
        drain();
        @(negedge clk);
        idle();
        push("oor_r4_same", 0, 0, ONES);
        push("oor_any", 2, 0, 0);
        push("oor_rd_after", 0, 2, 64'h0);
        push("oor_r7_same", 0, 1, 64'h78);
        drain();

        // mid-operation reset on both builds
        @(negedge clk);
        a_iss_en = 1; a_iss_idx = 2;
        b_iss_en = 1; b_iss_idx = 2;
        @(negedge clk);
        idle();
        a_wr0_en = 1; a_wr0_idx = 17; a_wr0_data = 64'h8000;
        b_wr1_en = 1; b_wr1_idx = 11; b_wr1_data = 64'h8000;
        a_rd(0, 17); a_rd(1, 2);
        push("pre_a_r17_byp", 0, 0, 64'h8000);
        push("pre_a_r2_busy", 1, 1, 1);
        drain();
        @(negedge clk);
        idle();
        b_rd(3, 11);
        push("pre_a_r17", 0, 0, 64'h8000);
        push("pre_b_r11", 3, 3, 64'h8000);
        push("pre_b_any", 5, 0, 1);
        drain();
        reset = 1;
        a_wr0_en = 1; a_wr0_idx = 17; a_wr0_data = 64'h1234;
        a_iss_en = 1; a_iss_idx = 3;
        b_wr0_en = 1; b_wr0_idx = 3; b_wr0_data = 64'h33;
        @(negedge clk);
        reset = 0;
        idle();
        a_rd(2, 3);
        b_rd(0, 2); b_rd(1, 3); b_rd(2, 8);
        push("mrst_a_r17", 0, 0, 64'h0);
        push("mrst_a_r2", 0, 1, ONES);
        push("mrst_a_r2_busy", 1, 1, 0);
        push("mrst_a_r3", 0, 2, ONES);
        push("mrst_a_r3_busy", 1, 2, 0);
        push("mrst_a_any", 2, 0, 0);
        push("mrst_b_r2", 3, 0, ONES);
        push("mrst_b_r2_busy", 4, 0, 0);
        push("mrst_b_r3", 3, 1, ONES);
        push("mrst_b_r8", 3, 2, 64'h0);
        push("mrst_b_r11", 3, 3, 64'h0);
        push("mrst_b_any", 5, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised multi-port register file that supersedes the fixed 18-register bank.
- Holds NGP general-purpose registers plus NSTK stack registers. Index NGP is fp, NGP+1 is sp, and any further indices are extra stack registers.
- Provides NRD combinational read ports with same-cycle write bypass, and two prioritised write ports.
- Includes a per-register busy scoreboard so the issue stage can detect read-after-write hazards. Sits between decode/issue and writeback in the CPU core.

Parameters:
- XLEN, 64, register width in bits.
- NGP, 16, number of general-purpose registers (indices 0..NGP-1).
- NSTK, 2, number of stack registers (indices NGP..NGP+NSTK-1); minimum 1.
- NRD, 3, number of read ports; minimum 1.
- GP_RESET_VALUE, {XLEN{1'b1}}, reset value of the general-purpose registers.
- STACK_RESET_VALUE, 0, reset value of the stack registers.
- Derived: NREG = NGP+NSTK; AW = $clog2(NREG), with a minimum of 1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- rd_idx  in  NRD*AW  read indices; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- rd_busy  out  NRD  per read port: the addressed register has an outstanding producer.
- wr0_en  in  1  write port 0 enable.
- wr0_idx  in  AW  write port 0 index.
- wr0_data  in  XLEN  write port 0 data.
- wr1_en  in  1  write port 1 enable.
- wr1_idx  in  AW  write port 1 index.
- wr1_data  in  XLEN  write port 1 data.
- iss_en  in  1  issue: mark register iss_idx busy.
- iss_idx  in  AW  register being claimed.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (clk edge with reset=1):
  - Registers 0..NGP-1 load GP_RESET_VALUE; NGP..NREG-1 load STACK_RESET_VALUE.
  - All busy bits clear.
  - Writes and issues in the same cycle are ignored.
  - Reset mid-operation discards all pending state; there is no partial retention.
- After reset: rd_data returns the reset values, rd_busy=0, busy_any=0.
- Writes:
  - Committed on the rising clk edge when the port's enable is set and idx < NREG.
  - An out-of-range write index is ignored and changes no state.
  - If both ports write the same index, wr1 wins.
- Reads:
  - Combinational, zero-cycle latency.
  - If a write with a matching idx is enabled in the same cycle, rd_data returns the incoming data (bypass), with wr1 taking priority over wr0. Otherwise it returns the stored value.
  - An out-of-range rd_idx returns 0 and rd_busy=0.
- Scoreboard, evaluated per register on each clk edge:
  - An enabled, in-range write to the register clears its busy bit.
  - An iss_en with a matching iss_idx sets the busy bit.
  - If a clear and a set hit the same register in the same cycle, the set wins (newer producer claimed).
  - An out-of-range iss_idx is ignored.
  - Issuing to an already-busy register keeps it busy; no counting, no error.
  - A write to a non-busy register is allowed and leaves it non-busy.
- rd_busy[k]:
  - Equals busy[rd_idx_k] AND NOT (a same-cycle enabled write to rd_idx_k). The bypassed value is valid, so no hazard is reported.
  - Same-cycle iss_en does not affect rd_busy; it takes effect from the next cycle.
- busy_any reflects the registered busy bits only.
- No internal FSM beyond the per-register scoreboard flops. All state lives in NREG x XLEN data flops plus NREG busy flops.

Test Plan:
- Reset with defaults, then read indices 0, 15, 16, 17 on three ports -> FFFF_FFFF_FFFF_FFFF, FFFF_FFFF_FFFF_FFFF, 0, 0; rd_busy=0; busy_any=0.
- wr0 idx 3 = 0x1234 and wr1 idx 3 = 0xABCD in the same cycle, with rd_idx0=3 in that cycle -> rd_data0=0xABCD (bypass); next cycle reg3 reads 0xABCD.
- iss_en idx 5, then read idx 5 -> rd_busy=1, busy_any=1. Next, wr0 idx 5 = 0x55 with rd_idx=5 in that cycle -> rd_data=0x55, rd_busy=0. Following cycle: busy_any=0.
- Same cycle: iss_en idx 7 and wr1 idx 7 = 0x77 -> reg7=0x77, busy[7] stays 1 afterwards.
- wr0 idx 20 (out of range, NREG=18) = 0x99, and read idx 20 -> no register changes; rd_data=0, rd_busy=0.
- Issue idx 2, write idx 17 = 0x8000, then assert reset for one cycle -> reg17=0, reg2=FFFF_FFFF_FFFF_FFFF, all busy clear. Repeat the reset check with NGP=8, NSTK=4, NRD=4.
